alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (e.g. main
//  datapath and an address/branch helper unit). Round-robin arbitration,
//  valid/ready handshake on request and response, operands and result
//  registered. Sits between the requesters and the ALU's op1/op2/ctrl
//  inputs and its out/EQ outputs.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; ALU must be instantiated with same
// PORTS
//  clk          in   1           system clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  req0_valid   in   1           requester 0 has an operation
//  req0_ready   out  1           requester 0 operation accepted this cycle
//  req0_op1     in   DATA_WIDTH  requester 0 operand 1
//  req0_op2     in   DATA_WIDTH  requester 0 operand 2
//  req0_ctrl    in   3           requester 0 ALU control code
//  req1_valid   in   1           requester 1 has an operation
//  req1_ready   out  1           requester 1 operation accepted this cycle
//  req1_op1     in   DATA_WIDTH  requester 1 operand 1
//  req1_op2     in   DATA_WIDTH  requester 1 operand 2
//  req1_ctrl    in   3           requester 1 ALU control code
//  rsp_valid    out  1           response available
//  rsp_ready    in   1           consumer takes response
//  rsp_id       out  1           requester that owns the response (0/1)
//  rsp_result   out  DATA_WIDTH  captured ALU result
//  rsp_eq       out  1           captured ALU EQ flag
//  alu_op1      out  DATA_WIDTH  to ALU operand 1 (from operand register)
//  alu_op2      out  DATA_WIDTH  to ALU operand 2 (from operand register)
//  alu_ctrl     out  3           to ALU control (from control register)
//  alu_out      in   DATA_WIDTH  from ALU result
//  alu_eq       in   1           from ALU EQ flag
// BEHAVIOUR
//  FSM states IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: grant = requester with valid; if both valid, the one NOT equal to
//    last_grant. reqN_ready = (state==IDLE) && reqN_valid && grant==N
//    (combinational, at most one high). On accept: latch op1/op2/ctrl and
//    id, go EXEC. No valid -> stay IDLE.
//  - EXEC: ALU driven from latched regs; at edge capture alu_out/alu_eq into
//    rsp_result/rsp_eq, go RESP.
//  - RESP: rsp_valid=1; rsp_id/result/eq stable while rsp_ready=0. On
//    rsp_valid&&rsp_ready: last_grant<=rsp_id, go IDLE.
//  - Latency: accepted in cycle T -> rsp_valid high in cycle T+2 (min).
//    Throughput 1 op per 3 cycles; no new accept before response taken.
//  - Requesters hold valid and operands stable until ready; a dropped valid
//    before ready is legal and grants nothing.
//  - ctrl passed through unmodified; unsupported codes yield ALU result 0.
//  - Reset: state=IDLE, last_grant=1 (requester 0 wins first tie),
//    rsp_valid=0, rsp_id=0, rsp_result=0, rsp_eq=0, operand/ctrl regs=0,
//    so alu_op1/op2/ctrl=0; req0/1_ready=0 during reset cycle.
//  - Reset mid-operation (EXEC or RESP): transaction discarded, no response,
//    rsp_valid low the cycle after rst sampled high.
// TESTING
//  1 rst high 2 cycles, no valids -> rsp_valid=0, both ready=0, alu_op*=0.
//  2 req0 ADD 5,7 (ctrl 000) -> req0_ready at T, rsp_valid at T+2,
//    rsp_id=0, rsp_result=12, rsp_eq=0.
//  3 both valid after reset, rsp_ready=1 -> grants 0,1,0,1 in order;
//    req0 SUB 9,9 -> result 0 eq=1; req1 SLT -1,1 -> result 1.
//  4 response with rsp_ready=0 for 4 cycles -> rsp fields stable, both
//    ready=0 despite valids; rsp_ready=1 -> IDLE next cycle.
//  5 only req1 valid, ctrl 110 -> granted though last_grant=0; result 0.
//  6 rst pulsed while in RESP -> rsp_valid=0 next cycle, next tie goes to 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Operands, control and result are registered; one operation in flight at a time.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_eq,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_grant;
  logic                  r_id;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [2:0]            r_ctrl;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_eq;
  logic                  w_grant;
  logic                  w_ready0;
  logic                  w_ready1;
  logic                  w_accept;
  logic                  w_take;

  // On a tie the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready0 = !rst && req0_valid && !w_grant;
        w_ready1 = !rst && req1_valid && w_grant;
        if (w_ready0 || w_ready1) w_state_nxt = S_EXEC;
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        w_take = rsp_ready;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = w_ready0 || w_ready1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_ctrl       <= '0;
      r_result     <= '0;
      r_eq         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id   <= w_grant;
        r_op1  <= w_grant ? req1_op1 : req0_op1;
        r_op2  <= w_grant ? req1_op2 : req0_op2;
        r_ctrl <= w_grant ? req1_ctrl : req0_ctrl;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_out;
        r_eq     <= alu_eq;
      end
      if (w_take) r_last_grant <= r_id;
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_eq     = r_eq;
  assign alu_op1    = r_op1;
  assign alu_op2    = r_op2;
  assign alu_ctrl   = r_ctrl;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and randomized checks of alu_share_arbiter
// A transaction-level model predicts grants, responses and ALU inputs every cycle.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic        rsp_valid, rsp_id, rsp_eq;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result, alu_op1, alu_op2, alu_out;
  logic [2:0]  alu_ctrl;
  logic        alu_eq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_eq(rsp_eq),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_eq(alu_eq)
  );

  // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, others give 0.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op1, alu_op2, alu_ctrl);
  assign alu_eq  = (alu_op1 == alu_op2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at most one transaction outstanding, visible from its 2nd cycle after accept.
  logic        m_out = 1'b0, m_last = 1'b1, m_id = 1'b0, m_eq = 1'b0;
  int          m_age = 0;
  logic [31:0] m_op1 = '0, m_op2 = '0, m_res = '0;
  logic [2:0]  m_ctrl = '0;
  logic        acc0 = 1'b0, acc1 = 1'b0;
  logic        e0, e1, pick, ev;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      m_out = 1'b0; m_last = 1'b1;
      m_op1 = '0; m_op2 = '0; m_ctrl = '0;
      acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      chk("alu_op1", alu_op1, m_op1);
      chk("alu_op2", alu_op2, m_op2);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      ev = m_out && (m_age >= 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_eq", 32'(rsp_eq), 32'(m_eq));
      end
      e0 = 1'b0; e1 = 1'b0;
      if (!m_out) begin
        pick = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        e0 = req0_valid && !pick;
        e1 = req1_valid && pick;
      end
      chk("ready0", 32'(req0_ready), 32'(e0));
      chk("ready1", 32'(req1_ready), 32'(e1));
      acc0 = req0_ready; acc1 = req1_ready;
      if (m_out) begin
        if (ev && rsp_ready) begin
          m_out = 1'b0; m_last = m_id;
        end else begin
          m_age++;
        end
      end else if (e0 || e1) begin
        m_out = 1'b1; m_age = 1; m_id = e1;
        m_op1 = e1 ? req1_op1 : req0_op1;
        m_op2 = e1 ? req1_op2 : req0_op2;
        m_ctrl = e1 ? req1_ctrl : req0_ctrl;
        m_res = alu_ref(m_op1, m_op2, m_ctrl);
        m_eq = (m_op1 == m_op2);
      end
    end
  end

  task automatic single(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, output logic [31:0] res, output logic eq,
                        output logic rid);
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
    end
    @(negedge clk);
    chk("single_ready", 32'(id ? req1_ready : req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("single_T1_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("single_T2_rsp_valid", 32'(rsp_valid), 1);
    res = rsp_result; eq = rsp_eq; rid = rsp_id;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 4)
      0:       return 32'($urandom % 8);
      1:       return 32'hFFFF_FFFF - 32'($urandom % 4);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] res;
  logic        eq, rid;
  int          g[$];
  logic [31:0] rq_res[$];
  logic        rq_eq[$], rq_id[$];

  initial begin
    // reset with no valids
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_alu_op1", alu_op1, 0);
    chk("t1_alu_op2", alu_op2, 0);
    chk("t1_alu_ctrl", 32'(alu_ctrl), 0);
    chk("t1_rsp_result", rsp_result, 0);

    // ADD 5,7 from requester 0
    single(1'b0, 32'd5, 32'd7, 3'd0, res, eq, rid);
    chk("t2_result", res, 12);
    chk("t2_eq", 32'(eq), 0);
    chk("t2_id", 32'(rid), 0);

    // both valid after reset: strict alternation starting at 0
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    req0_valid = 1'b1; req0_op1 = 32'd9; req0_op2 = 32'd9; req0_ctrl = 3'd1;
    req1_valid = 1'b1; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'd1; req1_ctrl = 3'd5;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (rsp_valid && rsp_ready) begin
        rq_res.push_back(rsp_result); rq_eq.push_back(rsp_eq); rq_id.push_back(rsp_id);
      end
      @(posedge clk); #1;
      if (g.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (rq_res.size() >= 4) break;
    end
    chk("t3_grant_count", g.size(), 4);
    for (int i = 0; i < 4; i++) if (i < g.size()) chk("t3_grant_order", g[i], i % 2);
    chk("t3_rsp_count", rq_res.size(), 4);
    if (rq_res.size() >= 2) begin
      chk("t3_sub_result", rq_res[0], 0);
      chk("t3_sub_eq", 32'(rq_eq[0]), 1);
      chk("t3_sub_id", 32'(rq_id[0]), 0);
      chk("t3_slt_result", rq_res[1], 1);
      chk("t3_slt_id", 32'(rq_id[1]), 1);
    end

    // stalled response blocks new accepts
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd2; req0_ctrl = 3'd0;
    @(negedge clk);
    chk("t4_accept0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_op1 = 32'd20; req0_op2 = 32'd4; req0_ctrl = 3'd1;
    req1_valid = 1'b1; req1_op1 = 32'd10; req1_op2 = 32'd3; req1_ctrl = 3'd0;
    @(negedge clk); @(negedge clk);
    chk("t4_rsp_valid", 32'(rsp_valid), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 1);
      chk("t4_hold_result", rsp_result, 3);
      chk("t4_hold_id", 32'(rsp_id), 0);
      chk("t4_hold_ready0", 32'(req0_ready), 0);
      chk("t4_hold_ready1", 32'(req1_ready), 0);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_idle_rsp_valid", 32'(rsp_valid), 0);
    chk("t4_idle_ready1", 32'(req1_ready), 1);
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // only requester 1 valid with last_grant=1... then 0; unsupported ctrl
    single(1'b0, 32'd2, 32'd2, 3'd0, res, eq, rid);
    chk("t5_pre_result", res, 4);
    single(1'b1, 32'd3, 32'd4, 3'd6, res, eq, rid);
    chk("t5_result", res, 0);
    chk("t5_id", 32'(rid), 1);

    // reset while in RESP; following tie must go to 0
    single(1'b0, 32'd6, 32'd1, 3'd1, res, eq, rid);
    chk("t6_pre_result", res, 5);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op1 = 32'd7; req1_op2 = 32'd8; req1_ctrl = 3'd0;
    @(negedge clk);
    chk("t6_accept1", 32'(req1_ready), 1);
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t6_in_resp", 32'(rsp_valid), 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_rsp_dropped", 32'(rsp_valid), 0);
    chk("t6_tie_ready0", 32'(req0_ready), 1);
    chk("t6_tie_ready1", 32'(req1_ready), 0);
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = (($urandom % 250) == 0);
      rsp_ready = (($urandom % 4) != 0);
      if (req0_valid && !acc0) begin
        if (($urandom % 16) == 0) req0_valid = 1'b0;
      end else begin
        req0_valid = 1'($urandom % 2);
        req0_op1 = rnd_op();
        req0_op2 = (($urandom % 4) == 0) ? req0_op1 : rnd_op();
        req0_ctrl = 3'($urandom % 8);
      end
      if (req1_valid && !acc1) begin
        if (($urandom % 16) == 0) req1_valid = 1'b0;
      end else begin
        req1_valid = 1'($urandom % 2);
        req1_op1 = rnd_op();
        req1_op2 = (($urandom % 4) == 0) ? req1_op1 : rnd_op();
        req1_ctrl = 3'($urandom % 8);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
